any1_issue_ctrl: RTL and testbench

ANY1_ISSUE_CTRL -- requirements
Module: any1_issue_ctrl

---
 rtl/any1_issue_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_any1_issue_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/any1_issue_ctrl.sv
// any1_issue_ctrl: two-entry decode-to-issue queue with a register scoreboard,
// a single-slot multicycle-unit tracker and a hazard stall counter.
module any1_issue_ctrl #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        rst_i,
  input  logic        clk_i,
  // decode side
  input  logic        dec_valid_i,
  output logic        dec_ready_o,
  input  logic [5:0]  dec_ra_i,
  input  logic [5:0]  dec_rb_i,
  input  logic [5:0]  dec_rt_i,
  input  logic        dec_rfwr_i,
  input  logic        dec_mc_i,
  input  logic [5:0]  dec_rid_i,
  // issue side
  output logic        iss_valid_o,
  input  logic        iss_ready_i,
  output logic [5:0]  iss_ra_o,
  output logic [5:0]  iss_rb_o,
  output logic [5:0]  iss_rt_o,
  output logic [5:0]  iss_rid_o,
  output logic        iss_rfwr_o,
  output logic        iss_mc_o,
  // writeback / multicycle completion
  input  logic        wb_valid_i,
  input  logic [5:0]  wb_rt_i,
  input  logic        mc_done_i,
  input  logic        flush_i,
  // status
  output logic        mc_busy_o,
  output logic [15:0] stall_cnt_o
);

  typedef struct packed {
    logic [5:0] ra;
    logic [5:0] rb;
    logic [5:0] rt;
    logic [5:0] rid;
    logic       rfwr;
    logic       mc;
  } entry_t;

  typedef enum logic {
    MC_IDLE,
    MC_BUSY
  } mc_state_e;

  // queue state
  entry_t     entry_q [DEPTH];
  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;

  // scoreboard, multicycle tracker, stall counter
  logic [63:0] sb_q, sb_d;
  mc_state_e   mc_state_q, mc_state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // combinational helpers
  entry_t head;
  logic   not_empty;
  logic   hazard;
  logic   mc_busy;
  logic   dec_ready;
  logic   iss_valid;
  logic   enq;
  logic   deq;

  // head selection, hazard detection and handshake qualification
  always_comb begin
    head      = entry_q[rd_ptr_q];
    mc_busy   = (mc_state_q == MC_BUSY);
    not_empty = (count_q != 2'd0);
    hazard    = sb_q[head.ra] | sb_q[head.rb] | (head.rfwr & sb_q[head.rt]) |
                (head.mc & mc_busy);
    dec_ready = (count_q < 2'(DEPTH)) & ~flush_i;
    iss_valid = not_empty & ~hazard & ~flush_i;
    enq       = dec_valid_i & dec_ready;
    deq       = iss_valid & iss_ready_i;
  end

  // output drive; head fields are masked while the queue is empty
  always_comb begin
    dec_ready_o = dec_ready;
    iss_valid_o = iss_valid;
    mc_busy_o   = mc_busy;
    stall_cnt_o = stall_cnt_q;
    iss_ra_o    = '0;
    iss_rb_o    = '0;
    iss_rt_o    = '0;
    iss_rid_o   = '0;
    iss_rfwr_o  = 1'b0;
    iss_mc_o    = 1'b0;
    if (not_empty) begin
      iss_ra_o   = head.ra;
      iss_rb_o   = head.rb;
      iss_rt_o   = head.rt;
      iss_rid_o  = head.rid;
      iss_rfwr_o = head.rfwr;
      iss_mc_o   = head.mc;
    end
  end

  // queue occupancy and pointer update
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush_i) begin
      // pointers realign with the empty count so a later single entry
      // lands at the head slot
      count_d  = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (enq) wr_ptr_d = ~wr_ptr_q;
      if (deq) rd_ptr_d = ~rd_ptr_q;
      case ({enq, deq})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // scoreboard: writeback clears first, so an issue to the same register wins
  always_comb begin
    sb_d = sb_q;
    if (wb_valid_i && (wb_rt_i != 6'd0)) sb_d[wb_rt_i] = 1'b0;
    if (deq && head.rfwr && (head.rt != 6'd0)) sb_d[head.rt] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // multicycle unit tracker next state
  always_comb begin
    mc_state_d = mc_state_q;
    case (mc_state_q)
      MC_IDLE: if (deq && head.mc) mc_state_d = MC_BUSY;
      MC_BUSY: if (mc_done_i)      mc_state_d = MC_IDLE;
      default:                     mc_state_d = MC_IDLE;
    endcase
  end

  // saturating count of cycles the head is held back by a hazard
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (not_empty && hazard && !flush_i && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // control state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q     <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      sb_q        <= '0;
      mc_state_q  <= MC_IDLE;
      stall_cnt_q <= '0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      sb_q        <= sb_d;
      mc_state_q  <= mc_state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // queue entry storage, written on enqueue only and never reset
  always_ff @(posedge clk_i) begin
    if (enq) begin
      entry_q[wr_ptr_q] <= '{ra:   dec_ra_i,
                             rb:   dec_rb_i,
                             rt:   dec_rt_i,
                             rid:  dec_rid_i,
                             rfwr: dec_rfwr_i,
                             mc:   dec_mc_i};
    end
  end

endmodule

// File: tb/tb_any1_issue_ctrl.sv
// Directed self-checking bench for any1_issue_ctrl.
module tb_any1_issue_ctrl;

  logic        rst_i, clk_i;
  logic        dec_valid_i, dec_ready_o;
  logic [5:0]  dec_ra_i, dec_rb_i, dec_rt_i, dec_rid_i;
  logic        dec_rfwr_i, dec_mc_i;
  logic        iss_valid_o, iss_ready_i;
  logic [5:0]  iss_ra_o, iss_rb_o, iss_rt_o, iss_rid_o;
  logic        iss_rfwr_o, iss_mc_o;
  logic        wb_valid_i;
  logic [5:0]  wb_rt_i;
  logic        mc_done_i, flush_i, mc_busy_o;
  logic [15:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  any1_issue_ctrl #(.DEPTH(2)) dut (
    .rst_i(rst_i), .clk_i(clk_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_ra_i(dec_ra_i), .dec_rb_i(dec_rb_i), .dec_rt_i(dec_rt_i),
    .dec_rfwr_i(dec_rfwr_i), .dec_mc_i(dec_mc_i), .dec_rid_i(dec_rid_i),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
    .iss_ra_o(iss_ra_o), .iss_rb_o(iss_rb_o), .iss_rt_o(iss_rt_o),
    .iss_rid_o(iss_rid_o), .iss_rfwr_o(iss_rfwr_o), .iss_mc_o(iss_mc_o),
    .wb_valid_i(wb_valid_i), .wb_rt_i(wb_rt_i), .mc_done_i(mc_done_i),
    .flush_i(flush_i), .mc_busy_o(mc_busy_o), .stall_cnt_o(stall_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [5:0] ra, input logic [5:0] rb,
                         input logic [5:0] rt, input logic rfwr, input logic mc,
                         input logic [5:0] rid);
    dec_valid_i = v;
    dec_ra_i = ra; dec_rb_i = rb; dec_rt_i = rt;
    dec_rfwr_i = rfwr; dec_mc_i = mc; dec_rid_i = rid;
  endtask

  task automatic zero_inputs();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    iss_ready_i = 1'b0; wb_valid_i = 1'b0; wb_rt_i = 6'd0;
    mc_done_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    zero_inputs();
    rst_i = 1'b1;
    #1;
    checks++; if (iss_valid_o !== 1'b0) begin errors++; $display("FAIL rst_iss_valid: got %b exp 0", iss_valid_o); end
    checks++; if (dec_ready_o !== 1'b1) begin errors++; $display("FAIL rst_dec_ready: got %b exp 1", dec_ready_o); end
    checks++; if (mc_busy_o !== 1'b0) begin errors++; $display("FAIL rst_mc_busy: got %b exp 0", mc_busy_o); end
    checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_stall: got %0d exp 0", stall_cnt_o); end
    tick();
    rst_i = 1'b0;
    #1;
    checks++; if ({iss_ra_o, iss_rb_o, iss_rt_o, iss_rid_o, iss_rfwr_o, iss_mc_o} !== 26'd0) begin errors++; $display("FAIL rst_iss_fields: got %h exp 0", {iss_ra_o, iss_rb_o, iss_rt_o, iss_rid_o, iss_rfwr_o, iss_mc_o}); end
    checks++; if (iss_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rel_iss_valid: got %b exp 0", iss_valid_o); end
  endtask

  task automatic test_basic_and_raw();
    do_reset();
    iss_ready_i = 1'b1;
    set_dec(1'b1, 6'd1, 6'd2, 6'd3, 1'b1, 1'b0, 6'd5);
    #1;
    checks++; if (dec_ready_o !== 1'b1) begin errors++; $display("FAIL basic_dec_ready: got %b exp 1", dec_ready_o); end
    checks++; if (iss_valid_o !== 1'b0) begin errors++; $display("FAIL basic_empty_valid: got %b exp 0", iss_valid_o); end
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    #1;
    checks++; if (iss_valid_o !== 1'b1) begin errors++; $display("FAIL basic_iss_valid: got %b exp 1", iss_valid_o); end
    checks++; if ({iss_ra_o, iss_rb_o, iss_rt_o, iss_rid_o} !== {6'd1, 6'd2, 6'd3, 6'd5}) begin errors++; $display("FAIL basic_fields: got %h exp %h", {iss_ra_o, iss_rb_o, iss_rt_o, iss_rid_o}, {6'd1, 6'd2, 6'd3, 6'd5}); end
    checks++; if ({iss_rfwr_o, iss_mc_o} !== 2'b10) begin errors++; $display("FAIL basic_flags: got %b exp 10", {iss_rfwr_o, iss_mc_o}); end
    tick();
    set_dec(1'b1, 6'd3, 6'd0, 6'd4, 1'b1, 1'b0, 6'd6);
    #1;
    checks++; if (iss_valid_o !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b exp 0", iss_valid_o); end
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    #1;
    checks++; if (iss_valid_o !== 1'b0) begin errors++; $display("FAIL raw_blocked: got %b exp 0", iss_valid_o); end
    checks++; if (iss_rid_o !== 6'd6) begin errors++; $display("FAIL raw_head_rid: got %0d exp 6", iss_rid_o); end
    checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL raw_stall0: got %0d exp 0", stall_cnt_o); end
    tick();
    checks++; if (stall_cnt_o !== 16'd1) begin errors++; $display("FAIL raw_stall1: got %0d exp 1", stall_cnt_o); end
    wb_valid_i = 1'b1; wb_rt_i = 6'd3;
    #1;
    checks++; if (iss_valid_o !== 1'b0) begin errors++; $display("FAIL raw_no_bypass: got %b exp 0", iss_valid_o); end
    tick();
    wb_valid_i = 1'b0;
    #1;
    checks++; if (iss_valid_o !== 1'b1) begin errors++; $display("FAIL raw_after_wb: got %b exp 1", iss_valid_o); end
    checks++; if (stall_cnt_o !== 16'd2) begin errors++; $display("FAIL raw_stall2: got %0d exp 2", stall_cnt_o); end
    tick();
    checks++; if (stall_cnt_o !== 16'd2) begin errors++; $display("FAIL raw_stall_hold: got %0d exp 2", stall_cnt_o); end
  endtask

  task automatic test_sb_collision();
    do_reset();
    iss_ready_i = 1'b1;
    set_dec(1'b1, 6'd0, 6'd0, 6'd5, 1'b1, 1'b0, 6'd1);
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    wb_valid_i = 1'b1; wb_rt_i = 6'd5;
    #1;
    checks++; if (iss_valid_o !== 1'b1) begin errors++; $display("FAIL coll_issue: got %b exp 1", iss_valid_o); end
    tick();
    wb_valid_i = 1'b0;
    set_dec(1'b1, 6'd5, 6'd0, 6'd0, 1'b0, 1'b0, 6'd2);
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    #1;
    checks++; if (iss_valid_o !== 1'b0) begin errors++; $display("FAIL coll_set_wins: got %b exp 0", iss_valid_o); end
    wb_valid_i = 1'b1; wb_rt_i = 6'd5;
    tick();
    wb_valid_i = 1'b0;
    #1;
    checks++; if (iss_valid_o !== 1'b1) begin errors++; $display("FAIL coll_cleared: got %b exp 1", iss_valid_o); end
    tick();
    set_dec(1'b1, 6'd0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd3);
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    tick();
    set_dec(1'b1, 6'd0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd4);
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    #1;
    checks++; if (iss_valid_o !== 1'b1) begin errors++; $display("FAIL r0_never_pending: got %b exp 1", iss_valid_o); end
    checks++; if (iss_rid_o !== 6'd4) begin errors++; $display("FAIL r0_head_rid: got %0d exp 4", iss_rid_o); end
    tick();
  endtask

  task automatic test_mc();
    do_reset();
    iss_ready_i = 1'b1;
    set_dec(1'b1, 6'd10, 6'd11, 6'd12, 1'b1, 1'b1, 6'd7);
    tick();
    set_dec(1'b1, 6'd20, 6'd21, 6'd22, 1'b1, 1'b1, 6'd8);
    #1;
    checks++; if ({iss_valid_o, iss_mc_o, mc_busy_o} !== 3'b110) begin errors++; $display("FAIL mc_div_issue: got %b exp 110", {iss_valid_o, iss_mc_o, mc_busy_o}); end
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    #1;
    checks++; if (mc_busy_o !== 1'b1) begin errors++; $display("FAIL mc_busy_set: got %b exp 1", mc_busy_o); end
    checks++; if (iss_valid_o !== 1'b0) begin errors++; $display("FAIL mc_mul_blocked: got %b exp 0", iss_valid_o); end
    checks++; if (iss_rid_o !== 6'd8) begin errors++; $display("FAIL mc_mul_head: got %0d exp 8", iss_rid_o); end
    tick();
    mc_done_i = 1'b1;
    #1;
    checks++; if (iss_valid_o !== 1'b0) begin errors++; $display("FAIL mc_done_same_cycle: got %b exp 0", iss_valid_o); end
    checks++; if (stall_cnt_o !== 16'd1) begin errors++; $display("FAIL mc_stall1: got %0d exp 1", stall_cnt_o); end
    tick();
    mc_done_i = 1'b0;
    #1;
    checks++; if ({mc_busy_o, iss_valid_o} !== 2'b01) begin errors++; $display("FAIL mc_mul_issuable: got %b exp 01", {mc_busy_o, iss_valid_o}); end
    checks++; if (stall_cnt_o !== 16'd2) begin errors++; $display("FAIL mc_stall2: got %0d exp 2", stall_cnt_o); end
    tick();
    #1;
    checks++; if ({mc_busy_o, iss_valid_o} !== 2'b10) begin errors++; $display("FAIL mc_mul_busy: got %b exp 10", {mc_busy_o, iss_valid_o}); end
    mc_done_i = 1'b1;
    tick();
    mc_done_i = 1'b0;
    #1;
    checks++; if (mc_busy_o !== 1'b0) begin errors++; $display("FAIL mc_idle_again: got %b exp 0", mc_busy_o); end
    mc_done_i = 1'b1;
    tick();
    mc_done_i = 1'b0;
    #1;
    checks++; if (mc_busy_o !== 1'b0) begin errors++; $display("FAIL mc_done_idle_ignored: got %b exp 0", mc_busy_o); end
  endtask

  task automatic test_full();
    do_reset();
    set_dec(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd1);
    tick();
    set_dec(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd2);
    #1;
    checks++; if (dec_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_c1: got %b exp 1", dec_ready_o); end
    tick();
    set_dec(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd3);
    #1;
    checks++; if (dec_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_c2: got %b exp 0", dec_ready_o); end
    tick(); tick();
    iss_ready_i = 1'b1;
    #1;
    checks++; if ({dec_ready_o, iss_valid_o} !== 2'b01) begin errors++; $display("FAIL full_no_enq_on_deq: got %b exp 01", {dec_ready_o, iss_valid_o}); end
    checks++; if (iss_rid_o !== 6'd1) begin errors++; $display("FAIL full_head1: got %0d exp 1", iss_rid_o); end
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    iss_ready_i = 1'b0;
    #1;
    checks++; if (dec_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_after_deq: got %b exp 1", dec_ready_o); end
    checks++; if (iss_rid_o !== 6'd2) begin errors++; $display("FAIL full_head2: got %0d exp 2", iss_rid_o); end
    set_dec(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd4);
    iss_ready_i = 1'b1;
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    iss_ready_i = 1'b0;
    #1;
    checks++; if ({iss_valid_o, dec_ready_o} !== 2'b11) begin errors++; $display("FAIL simul_count1: got %b exp 11", {iss_valid_o, dec_ready_o}); end
    checks++; if (iss_rid_o !== 6'd4) begin errors++; $display("FAIL simul_new_head: got %0d exp 4", iss_rid_o); end
    iss_ready_i = 1'b1;
    tick();
    iss_ready_i = 1'b0;
    #1;
    checks++; if ({iss_valid_o, iss_rid_o} !== 7'd0) begin errors++; $display("FAIL full_drained: got %h exp 0", {iss_valid_o, iss_rid_o}); end
  endtask

  task automatic test_flush();
    do_reset();
    iss_ready_i = 1'b1;
    set_dec(1'b1, 6'd0, 6'd0, 6'd30, 1'b1, 1'b0, 6'd10);
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    tick();
    iss_ready_i = 1'b0;
    set_dec(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd11);
    tick();
    set_dec(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd12);
    tick();
    set_dec(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd13);
    iss_ready_i = 1'b1;
    flush_i = 1'b1;
    #1;
    checks++; if ({iss_valid_o, dec_ready_o} !== 2'b00) begin errors++; $display("FAIL flush_suppress: got %b exp 00", {iss_valid_o, dec_ready_o}); end
    tick();
    flush_i = 1'b0;
    iss_ready_i = 1'b0;
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    #1;
    checks++; if ({iss_valid_o, iss_rid_o, dec_ready_o} !== 8'b0000_0001) begin errors++; $display("FAIL flush_empty: got %b exp 00000001", {iss_valid_o, iss_rid_o, dec_ready_o}); end
    set_dec(1'b1, 6'd30, 6'd0, 6'd0, 1'b0, 1'b0, 6'd14);
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    #1;
    checks++; if (iss_valid_o !== 1'b0) begin errors++; $display("FAIL flush_sb_kept: got %b exp 0", iss_valid_o); end
    checks++; if (iss_rid_o !== 6'd14) begin errors++; $display("FAIL flush_realign_head: got %0d exp 14", iss_rid_o); end
    wb_valid_i = 1'b1; wb_rt_i = 6'd30;
    tick();
    wb_valid_i = 1'b0;
    #1;
    checks++; if (iss_valid_o !== 1'b1) begin errors++; $display("FAIL flush_post_wb: got %b exp 1", iss_valid_o); end
  endtask

  task automatic test_stall_saturate();
    do_reset();
    iss_ready_i = 1'b1;
    set_dec(1'b1, 6'd0, 6'd0, 6'd50, 1'b1, 1'b0, 6'd1);
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    tick();
    set_dec(1'b1, 6'd50, 6'd0, 6'd0, 1'b0, 1'b0, 6'd2);
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    repeat (65534) tick();
    checks++; if (stall_cnt_o !== 16'hFFFE) begin errors++; $display("FAIL stall_fffe: got %h exp fffe", stall_cnt_o); end
    tick();
    checks++; if (stall_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL stall_ffff: got %h exp ffff", stall_cnt_o); end
    repeat (3) tick();
    checks++; if (stall_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL stall_saturated: got %h exp ffff", stall_cnt_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    iss_ready_i = 1'b1;
    set_dec(1'b1, 6'd0, 6'd0, 6'd40, 1'b1, 1'b1, 6'd20);
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    tick();
    iss_ready_i = 1'b0;
    set_dec(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd21);
    tick();
    set_dec(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd22);
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    #1;
    checks++; if ({mc_busy_o, dec_ready_o, iss_valid_o} !== 3'b101) begin errors++; $display("FAIL arst_pre: got %b exp 101", {mc_busy_o, dec_ready_o, iss_valid_o}); end
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if ({iss_valid_o, mc_busy_o, dec_ready_o} !== 3'b001) begin errors++; $display("FAIL arst_ctrl: got %b exp 001", {iss_valid_o, mc_busy_o, dec_ready_o}); end
    checks++; if ({stall_cnt_o, iss_rid_o} !== 22'd0) begin errors++; $display("FAIL arst_stall_rid: got %h exp 0", {stall_cnt_o, iss_rid_o}); end
    tick();
    rst_i = 1'b0;
    iss_ready_i = 1'b1;
    set_dec(1'b1, 6'd40, 6'd0, 6'd0, 1'b0, 1'b1, 6'd23);
    tick();
    set_dec(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    #1;
    checks++; if ({iss_valid_o, iss_rid_o} !== {1'b1, 6'd23}) begin errors++; $display("FAIL arst_sb_mc_clear: got %h exp %h", {iss_valid_o, iss_rid_o}, {1'b1, 6'd23}); end
  endtask

  initial begin
    zero_inputs();
    rst_i = 1'b1;
    test_reset();
    test_basic_and_raw();
    test_sb_collision();
    test_mc();
    test_full();
    test_flush();
    test_stall_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
